// File: rtl/clic_entry_table_pkg.sv
// Shared types for the CLIC entry table: source indexing, priority width,
// per-source state record and the software field-select encoding.
package clic_entry_table_pkg;

    localparam int NR_INDEX_BITS = 3;
    localparam int NR_PRIO_BITS  = 3;
    localparam int NR_SOURCES    = 2 ** NR_INDEX_BITS;

    typedef logic [NR_INDEX_BITS-1:0] Index;
    typedef logic [NR_PRIO_BITS-1:0]  Entry;
    typedef Entry [NR_SOURCES-1:0]    Entries;

    typedef enum logic [1:0] {
        PRIO    = 2'b00,
        ENABLE  = 2'b01,
        PENDING = 2'b10,
        TRIG    = 2'b11
    } field_e;

    // Packed order gives {trig, pending, enable, prio} directly on readback.
    typedef struct packed {
        logic trig;
        logic pending;
        logic enable;
        Entry prio;
    } EntryState;

    typedef EntryState [NR_SOURCES-1:0] EntryStates;

    // Priority 0 doubles as "not requesting", so masking just forces 0.
    function automatic Entry mask_entry(input EntryState e);
        return (e.pending && e.enable) ? e.prio : '0;
    endfunction

endpackage

// File: rtl/clic_irq_sync.sv
// SYNC_STAGES-deep synchroniser for the raw interrupt lines plus one
// edge-history flop; rise_o flags a 0->1 transition of the synchronised line.
module clic_irq_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] irq_i,
    output logic [WIDTH-1:0] irq_s_o,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            hist_q <= '0;
        end else begin
            sync_q[0] <= irq_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            // History runs regardless of trigger mode so a level->edge switch
            // with the line already high never looks like a fresh edge.
            hist_q <= irq_s_o;
        end
    end

    assign irq_s_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = irq_s_o & ~hist_q;

endmodule

// File: rtl/clic_entry_table.sv
// Per-source CLIC state (prio/enable/pending/trig) with software writes and
// claims; drives the masked priority vector consumed by the arbiter.
module clic_entry_table
    import clic_entry_table_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NR_SOURCES-1:0]   irq_i,
    input  logic                    wr_en,
    input  Index                    wr_index,
    input  logic [1:0]              wr_field,
    input  Entry                    wr_data,
    input  logic                    claim_valid,
    input  Index                    claim_index,
    input  Index                    rd_index,
    output logic [NR_PRIO_BITS+2:0] rd_data,
    output Entries                  entries
);

    EntryStates            table_q, table_d;
    logic [NR_SOURCES-1:0] irq_s, rise;
    logic [NR_SOURCES-1:0] wr_sel, clm_sel;
    field_e                field;

    clic_irq_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (NR_SOURCES)
    ) u_irq_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq_i   (irq_i),
        .irq_s_o (irq_s),
        .rise_o  (rise)
    );

    assign field = field_e'(wr_field);

    always_comb begin
        wr_sel  = '0;
        clm_sel = '0;
        if (wr_en) begin
            wr_sel[wr_index] = 1'b1;
        end
        if (claim_valid) begin
            clm_sel[claim_index] = 1'b1;
        end
    end

    always_comb begin
        table_d = table_q;
        for (int i = 0; i < NR_SOURCES; i++) begin
            if (wr_sel[i]) begin
                case (field)
                    PRIO:    table_d[i].prio   = wr_data;
                    ENABLE:  table_d[i].enable = wr_data[0];
                    TRIG:    table_d[i].trig   = wr_data[0];
                    default: ;
                endcase
            end

            // Pending uses the mode in force before any same-cycle trig write.
            if (!table_q[i].trig) begin
                table_d[i].pending = irq_s[i];
            end else if (rise[i]) begin
                table_d[i].pending = 1'b1;
            end else if (wr_sel[i] && field == PENDING) begin
                table_d[i].pending = wr_data[0];
            end else if (clm_sel[i]) begin
                table_d[i].pending = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            table_q <= '0;
        end else begin
            table_q <= table_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NR_SOURCES; i++) begin
            entries[i] = mask_entry(table_q[i]);
        end
    end

    assign rd_data = table_q[rd_index];

endmodule

// File: tb/tb_clic_entry_table.sv
// Directed test-plan steps followed by random traffic, all checked against
// a per-source behavioural model of the CLIC table.
module tb_clic_entry_table;
    import clic_entry_table_pkg::*;

    localparam int S = 2;

    logic                    clk;
    logic                    rst_n;
    logic [NR_SOURCES-1:0]   irq_i;
    logic                    wr_en;
    Index                    wr_index;
    logic [1:0]              wr_field;
    Entry                    wr_data;
    logic                    claim_valid;
    Index                    claim_index;
    Index                    rd_index;
    logic [NR_PRIO_BITS+2:0] rd_data;
    Entries                  entries;

    int vectors;
    int miscompares;

    int   m_prio [NR_SOURCES];
    bit   m_en   [NR_SOURCES];
    bit   m_pend [NR_SOURCES];
    bit   m_trig [NR_SOURCES];
    logic [NR_SOURCES-1:0] hist [$];

    clic_entry_table #(.SYNC_STAGES(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_i       (irq_i),
        .wr_en       (wr_en),
        .wr_index    (wr_index),
        .wr_field    (wr_field),
        .wr_data     (wr_data),
        .claim_valid (claim_valid),
        .claim_index (claim_index),
        .rd_index    (rd_index),
        .rd_data     (rd_data),
        .entries     (entries)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR_SOURCES; i++) begin
            m_prio[i] = 0; m_en[i] = 0; m_pend[i] = 0; m_trig[i] = 0;
        end
        hist.delete();
        for (int k = 0; k <= S; k++) hist.push_back('0);
    endtask

    // hist[0] is the newest sample; the synchronised line is S-1 edges older,
    // and the previous synchronised value one edge older still.
    task automatic model_update();
        for (int i = 0; i < NR_SOURCES; i++) begin
            bit s_now, s_old, wr_hit, cl_hit;
            s_now  = hist[S-1][i];
            s_old  = hist[S][i];
            wr_hit = wr_en && (int'(wr_index) == i);
            cl_hit = claim_valid && (int'(claim_index) == i);
            if (!m_trig[i])                  m_pend[i] = s_now;
            else if (s_now && !s_old)        m_pend[i] = 1'b1;
            else if (wr_hit && wr_field == 2'b10) m_pend[i] = wr_data[0];
            else if (cl_hit)                 m_pend[i] = 1'b0;
            if (wr_hit && wr_field == 2'b00) m_prio[i] = int'(wr_data);
            if (wr_hit && wr_field == 2'b01) m_en[i]   = wr_data[0];
            if (wr_hit && wr_field == 2'b11) m_trig[i] = wr_data[0];
        end
        hist.push_front(irq_i);
        void'(hist.pop_back());
    endtask

    function automatic int exp_entry(input int i);
        return (m_pend[i] && m_en[i]) ? m_prio[i] : 0;
    endfunction

    function automatic int exp_rd(input int i);
        return (int'(m_trig[i]) * 32) + (int'(m_pend[i]) * 16) + (int'(m_en[i]) * 8) + m_prio[i];
    endfunction

    task automatic check_all();
        int r;
        for (int i = 0; i < NR_SOURCES; i++) begin
            chk($sformatf("entries[%0d]", i), 32'(entries[i]), 32'(exp_entry(i)));
        end
        r = $urandom_range(0, NR_SOURCES-1);
        rd_index = Index'(r);
        #1;
        chk($sformatf("rd_data[%0d]", r), 32'(rd_data), 32'(exp_rd(r)));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wr(input int idx, input logic [1:0] f, input int d);
        wr_en = 1'b1; wr_index = Index'(idx); wr_field = f; wr_data = Entry'(d);
        step();
        wr_en = 1'b0;
    endtask

    task automatic claim(input int idx);
        claim_valid = 1'b1; claim_index = Index'(idx);
        step();
        claim_valid = 1'b0;
    endtask

    task automatic chk_pend(input string tag, input int idx, input int exp);
        rd_index = Index'(idx);
        #1;
        chk(tag, 32'(rd_data[NR_PRIO_BITS+1]), 32'(exp));
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; irq_i = '0; wr_en = 1'b0; wr_index = '0; wr_field = '0;
        wr_data = '0; claim_valid = 1'b0; claim_index = '0; rd_index = '0;
        model_reset();
        #12 rst_n = 1'b1;

        for (int i = 0; i < NR_SOURCES; i++) begin
            rd_index = Index'(i);
            #1;
            chk($sformatf("reset_rd[%0d]", i), 32'(rd_data), 32'h0);
        end
        chk("reset_entries", 32'(entries), 32'h0);

        // Source 5: edge mode, 2-cycle pulse, then claim.
        wr(5, PRIO, 6); wr(5, ENABLE, 1); wr(5, TRIG, 1);
        irq_i[5] = 1'b1; step();
        chk("src5_edge1", 32'(entries[5]), 32'h0);
        step();
        chk("src5_edge2", 32'(entries[5]), 32'h0);
        irq_i[5] = 1'b0; step();
        chk("src5_edge3", 32'(entries[5]), 32'h6);
        claim(5);
        chk("src5_claim", 32'(entries[5]), 32'h0);
        irq_i[5] = 1'b1; steps(3);
        chk("src5_hold_rise", 32'(entries[5]), 32'h6);
        claim(5); steps(4);
        chk("src5_hold_no_repend", 32'(entries[5]), 32'h0);
        irq_i[5] = 1'b0; steps(3);

        // Source 2: level mode follows the line; claims are ignored.
        wr(2, PRIO, 3); wr(2, ENABLE, 1);
        irq_i[2] = 1'b1; steps(2);
        chk("src2_edge2", 32'(entries[2]), 32'h0);
        step();
        chk("src2_edge3", 32'(entries[2]), 32'h3);
        claim(2);
        chk("src2_claim_noop", 32'(entries[2]), 32'h3);
        irq_i[2] = 1'b0; steps(2);
        chk("src2_drop_edge2", 32'(entries[2]), 32'h3);
        step();
        chk("src2_drop_edge3", 32'(entries[2]), 32'h0);

        // Source 1: edge beats claim, software write beats claim.
        wr(1, TRIG, 1); wr(1, PENDING, 1);
        irq_i[1] = 1'b1; steps(2);
        claim(1);
        chk_pend("src1_rise_vs_claim", 1, 1);
        wr_en = 1'b1; wr_index = Index'(1); wr_field = PENDING; wr_data = Entry'(1);
        claim_valid = 1'b1; claim_index = Index'(1);
        step();
        wr_en = 1'b0; claim_valid = 1'b0;
        chk_pend("src1_wr_vs_claim", 1, 1);
        irq_i[1] = 1'b0; steps(2);

        // Source 7: priority 0 masks while pending is kept.
        wr(7, TRIG, 1); wr(7, PENDING, 1); wr(7, ENABLE, 1); wr(7, PRIO, 4);
        chk("src7_active", 32'(entries[7]), 32'h4);
        wr(7, PRIO, 0);
        chk("src7_prio0", 32'(entries[7]), 32'h0);
        chk_pend("src7_prio0_pend", 7, 1);
        wr(7, ENABLE, 0); wr(7, PRIO, 4);
        chk("src7_disabled", 32'(entries[7]), 32'h0);

        // Source 3: level to edge with the line high creates no edge.
        irq_i[3] = 1'b1; steps(3);
        chk_pend("src3_level_pend", 3, 1);
        wr(3, TRIG, 1); steps(3);
        chk_pend("src3_switch_keep", 3, 1);
        claim(3); steps(3);
        chk_pend("src3_claimed_hold", 3, 0);
        irq_i[3] = 1'b0; steps(3);

        // Mid-operation asynchronous reset.
        wr(5, PENDING, 1);
        chk("pre_arst_entries5", 32'(entries[5]), 32'h6);
        #1 rst_n = 1'b0;
        #1 chk("arst_entries", 32'(entries), 32'h0);
        model_reset();
        #2 rst_n = 1'b1;
        steps(2);

        for (int n = 0; n < 400; n++) begin
            for (int b = 0; b < NR_SOURCES; b++) begin
                if ($urandom_range(0, 5) == 0) irq_i[b] = ~irq_i[b];
            end
            wr_en       = 1'($urandom_range(0, 1));
            wr_index    = Index'($urandom);
            wr_field    = 2'($urandom);
            wr_data     = Entry'($urandom);
            claim_valid = ($urandom_range(0, 2) == 0);
            claim_index = Index'($urandom);
            step();
        end
        wr_en = 1'b0; claim_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clic_entry_table.md
Name: clic_entry_table

Overview:
- Upstream stage of the CLIC priority arbiter.
- Holds per-source interrupt state: priority, enable, pending and trigger mode.
- Synchronises the raw interrupt lines and captures edges.
- Services software register writes and claim-clears from the core side.
- Presents a masked Entries vector to the arbiter. An entry is its priority when pending and enabled, else 0. Priority 0 is reserved to mean "not requesting".

Parameters:
- SYNC_STAGES, 2, depth of the irq input synchroniser flop chain; legal range is 1 or more.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- irq_i  input  2**NR_INDEX_BITS  raw interrupt lines, asynchronous to clk, one per source
- wr_en  input  1  register write strobe, one write per cycle
- wr_index  input  Index  target source of the write
- wr_field  input  2  field select: 00 prio, 01 enable, 10 pending, 11 trig
- wr_data  input  NR_PRIO_BITS  write data; bit 0 only for enable, pending and trig
- claim_valid  input  1  core claims a source this cycle
- claim_index  input  Index  claimed source
- rd_index  input  Index  combinational read select
- rd_data  output  NR_PRIO_BITS+3  {trig, pending, enable, prio} of rd_index
- entries  output  Entries  masked entries to the arbiter

Behaviour:
- Reset (async assert, sync deassert in clk domain):
  - All prio = 0, enable = 0, pending = 0, trig = 0 (level).
  - Synchroniser flops and edge-history flops = 0.
  - entries = all 0; rd_data reflects the reset state.
- Synchroniser: irq_i passes through SYNC_STAGES flops to give irq_s. The edge-history flop irq_q <= irq_s every cycle, independent of trig.
- Rising edge: rise[i] = irq_s[i] & ~irq_q[i].
- Level mode (trig=0):
  - pending[i] <= irq_s[i] every cycle.
  - Software pending writes and claims have no effect on pending.
- Edge mode (trig=1), per cycle for index i:
  - If rise[i]: pending <= 1. An edge wins over any same-cycle clear.
  - Else if wr_en and wr_field = 10 and wr_index = i: pending <= wr_data[0]. Software wins over a same-cycle claim.
  - Else if claim_valid and claim_index = i: pending <= 0.
  - Else hold.
- prio, enable and trig change only on a matching write. New values are visible in entries and rd_data the cycle after the write edge.
- Mode switch:
  - Level to edge: pending keeps its current value; irq_q is continuous, so no spurious edge is generated.
  - Edge to level: pending follows irq_s from the next cycle.
- Output: entries[i] = (pending[i] & enable[i]) ? prio[i] : 0. Combinational from state flops only; no combinational path from any input port to entries.
- Latency:
  - irq_i rise to entries update: SYNC_STAGES+1 clk edges, in both modes.
  - Write to entries update: 1 edge.
  - Claim to entries clear: 1 edge.
- Boundaries:
  - Claim of a non-pending or level-mode source is a no-op.
  - Writing prio = 0 masks the source while keeping pending.
  - A pulse shorter than one clk period may be missed; no requirement applies.
  - Duplicate non-zero priorities are software's responsibility; this block does not check them.
- rd_data is purely combinational from state and rd_index.

Decomposition:
- common_pkg additions:
  - Field-select enum (PRIO, ENABLE, PENDING, TRIG).
  - EntryState struct {trig, pending, enable, prio}.
  - EntryStates array type.
- Reuse the existing Index, Entry, Entries, NR_INDEX_BITS and NR_PRIO_BITS.
- One natural sub-module, clic_irq_sync: a parameterised SYNC_STAGES-deep synchroniser plus edge-history flop, producing irq_s and rise for the whole vector.
- The table and the masking live in clic_entry_table.

Test Plan (NR_INDEX_BITS=3, NR_PRIO_BITS=3, SYNC_STAGES=2):
- Reset, then read all 8 rd_data -> all 0 and entries all 0. Assert rst_n low mid-operation -> entries go to 0 immediately, without a clk edge.
- Source 5: write prio=6, enable=1, trig=1, then pulse irq_i[5] high for 2 cycles -> entries[5]=6 exactly 3 edges after the rise. Claim index 5 -> entries[5]=0 the next cycle. irq_i[5] held high produces no re-pend.
- Source 2 level mode, prio=3, enable=1: raise irq_i[2] -> entries[2]=3 after 3 edges. Claim 2 -> no change. Drop irq_i[2] -> entries[2]=0 after 3 edges.
- Source 1 edge mode, pending=1: rise[1] and claim of 1 in the same cycle -> pending stays 1. Software write pending=1 and claim of 1 in the same cycle -> pending=1.
- Source 7: pending=1, enable=1, prio=4 -> entries[7]=4. Write prio=0 -> entries[7]=0 while rd_data.pending=1. Write enable=0 then prio=4 -> entries[7] stays 0.
- Source 3: irq_i[3] high in level mode, then switch to trig=1 -> no extra edge; pending stays 1 until claimed. After the claim, pending stays 0 while the line is held high.
